// File: rtl/irq_prio_ctrl_if.sv
// Host-side handshake of the interrupt priority controller.
// The controller drives the request/id/service flags; the host answers with ack/eoi.
interface irq_prio_ctrl_if #(
    parameter int ID_W = 5
);
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic            in_service;
    logic            ack;
    logic            eoi;

    modport master (output irq_req, irq_id, in_service, input ack, eoi);
    modport slave  (input irq_req, irq_id, in_service, output ack, eoi);
endinterface

// File: rtl/irq_prio_ctrl.sv
// Registered interrupt priority controller: edge-captured pending latches, mask/group gating,
// req/ack/eoi handshake. Define PRIO_ROTATE_EN for round-robin priority (default: fixed, ch0 highest).
module irq_prio_ctrl #(
    parameter int NUM_CH  = 27,
    parameter int NUM_GRP = 3,
    parameter int ID_W    = 5
) (
    input  logic               CK,
    input  logic               RST,
    input  logic [NUM_CH-1:0]  irq_in,
    input  logic [NUM_CH-1:0]  mask,
    input  logic [NUM_GRP-1:0] grp_en,
    irq_prio_ctrl_if.master    host,
    output logic [NUM_CH-1:0]  pending
);
    localparam int GRP_SZ = NUM_CH / NUM_GRP;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state;
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] grp_full;
    logic [NUM_CH-1:0] eff;
    logic [NUM_CH-1:0] clr;
    logic [ID_W-1:0]   win;

    always_comb begin
        grp_full = '0;
        for (int i = 0; i < NUM_CH; i++) grp_full[i] = grp_en[i / GRP_SZ];
    end

    assign rise = irq_in & ~irq_q;
    assign eff  = pending & mask & grp_full;

    always_comb begin
        clr = '0;
        if (state == REQ && host.ack) clr[host.irq_id] = 1'b1;
    end

`ifdef PRIO_ROTATE_EN
    localparam logic [ID_W:0]   NCH  = (ID_W+1)'(NUM_CH);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_CH - 1);
    logic [ID_W-1:0] rot_ptr;
    logic [ID_W:0]   sum;

    // Walk offsets from farthest to nearest so the channel closest to rot_ptr wins.
    always_comb begin
        win = '0;
        sum = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = {1'b0, rot_ptr} + (ID_W+1)'(k);
            if (sum >= NCH) sum = sum - NCH;
            if (eff[sum[ID_W-1:0]]) win = sum[ID_W-1:0];
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST)
            rot_ptr <= '0;
        else if (state == REQ && host.ack)
            rot_ptr <= (host.irq_id == LAST) ? '0 : host.irq_id + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (eff[i]) win = ID_W'(i);
    end
`endif

    // A new edge in the same cycle as the ack-clear keeps the latch set.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~clr) | rise;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            host.irq_req    <= 1'b0;
            host.irq_id     <= '0;
            host.in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|eff) begin
                    host.irq_id  <= win;
                    host.irq_req <= 1'b1;
                    state        <= REQ;
                end
                REQ: if (host.ack) begin
                    host.irq_req    <= 1'b0;
                    host.in_service <= 1'b1;
                    state           <= SERVICE;
                end else if (!eff[host.irq_id]) begin
                    host.irq_req <= 1'b0;
                    state        <= IDLE;
                end
                SERVICE: if (host.eoi) begin
                    host.in_service <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: expected request ids are queued by the stimulus and
// popped by a monitor on every new irq_req; other state is checked inline.
module tb_irq_prio_ctrl;
    localparam int NUM_CH = 27, NUM_GRP = 3, ID_W = 5;

    logic               CK = 0;
    logic               RST;
    logic [NUM_CH-1:0]  irq_in;
    logic [NUM_CH-1:0]  mask;
    logic [NUM_GRP-1:0] grp_en;
    logic [NUM_CH-1:0]  pending;

    irq_prio_ctrl_if #(.ID_W(ID_W)) bus ();

    irq_prio_ctrl #(.NUM_CH(NUM_CH), .NUM_GRP(NUM_GRP), .ID_W(ID_W)) dut (
        .CK(CK), .RST(RST), .irq_in(irq_in), .mask(mask), .grp_en(grp_en),
        .host(bus), .pending(pending)
    );

    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic req_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every fresh request must match the next queued id.
    always @(negedge CK) begin
        if (RST) req_prev <= 1'b0;
        else begin
            if (bus.irq_req && !req_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got id %0d expected no request", bus.irq_id);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (32'(bus.irq_id) != e) begin
                        errors++;
                        $display("FAIL sb_id: got %0d expected %0d", bus.irq_id, e);
                    end
                end
            end
            req_prev <= bus.irq_req;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        @(negedge CK);
        while (!bus.irq_req && n < 20) begin
            @(negedge CK);
            n++;
        end
        chk(name, 32'(bus.irq_req), 1);
    endtask

    task automatic do_ack();
        bus.ack = 1; cyc(1); bus.ack = 0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1; cyc(1); bus.eoi = 0;
    endtask

    initial begin
        RST = 1; irq_in = '0; mask = '1; grp_en = '1; bus.ack = 0; bus.eoi = 0;
        cyc(2);
        RST = 0;
        @(negedge CK);
        chk("rst_req", 32'(bus.irq_req), 0);
        chk("rst_id", 32'(bus.irq_id), 0);
        chk("rst_insvc", 32'(bus.in_service), 0);
        chk("rst_pending", 32'(pending), 0);

        // Single channel, latency and handshake
        cyc(1);
        exp_q.push_back(5);
        irq_in[5] = 1;
        cyc(1); @(negedge CK);
        chk("lat_pending5", 32'(pending[5]), 1);
        chk("lat_req_early", 32'(bus.irq_req), 0);
        cyc(1); @(negedge CK);
        chk("lat_req", 32'(bus.irq_req), 1);
        do_ack(); @(negedge CK);
        chk("ack_pending5", 32'(pending[5]), 0);
        chk("ack_insvc", 32'(bus.in_service), 1);
        chk("ack_req", 32'(bus.irq_req), 0);
        do_eoi(); @(negedge CK);
        chk("eoi_insvc", 32'(bus.in_service), 0);

        // Fixed priority with back-to-back timing
        irq_in = '0; cyc(1);
        exp_q.push_back(3); exp_q.push_back(20);
        irq_in[3] = 1; irq_in[20] = 1;
        wait_req("prio_req");
        do_ack(); @(negedge CK);
        chk("prio_pending20", 32'(pending[20]), 1);
        do_eoi(); @(negedge CK);
        chk("b2b_idle", 32'(bus.irq_req), 0);
        cyc(1); @(negedge CK);
        chk("b2b_req", 32'(bus.irq_req), 1);
        do_ack(); do_eoi();

        // Priority after servicing 3 with 1 and 20 pending
        irq_in = '0; cyc(1);
        exp_q.push_back(3);
`ifdef PRIO_ROTATE_EN
        exp_q.push_back(20); exp_q.push_back(1);
`else
        exp_q.push_back(1); exp_q.push_back(20);
`endif
        irq_in[3] = 1;
        wait_req("rot_req3");
        do_ack();
        irq_in[1] = 1; irq_in[20] = 1;
        cyc(2);
        do_eoi();
        wait_req("rot_req_a"); do_ack(); do_eoi();
        wait_req("rot_req_b"); do_ack(); do_eoi();

        // Group and mask gating
        irq_in = '0; cyc(1);
        grp_en = 3'b110;
        irq_in[2] = 1;
        cyc(4); @(negedge CK);
        chk("gate_noreq", 32'(bus.irq_req), 0);
        chk("gate_pending2", 32'(pending[2]), 1);
        exp_q.push_back(2);
        grp_en = 3'b111;
        wait_req("gate_req");
        mask[2] = 0;
        cyc(1); @(negedge CK);
        chk("mask_drop", 32'(bus.irq_req), 0);
        chk("mask_pending2", 32'(pending[2]), 1);
        cyc(2); @(negedge CK);
        chk("mask_stay_idle", 32'(bus.irq_req), 0);
        exp_q.push_back(2);
        mask[2] = 1;
        wait_req("unmask_req"); do_ack(); do_eoi();

        // Re-edge in the ack cycle keeps pending set
        irq_in = '0; cyc(1);
        exp_q.push_back(7);
        irq_in[7] = 1;
        wait_req("coal_req");
        irq_in[7] = 0; cyc(1);
        irq_in[7] = 1; bus.ack = 1;
        cyc(1); bus.ack = 0;
        @(negedge CK);
        chk("coal_pending7", 32'(pending[7]), 1);
        chk("coal_insvc", 32'(bus.in_service), 1);
        exp_q.push_back(7);
        do_eoi();
        wait_req("coal_rereq"); do_ack(); do_eoi();

        // Async reset in the middle of service
        irq_in = '0; cyc(1);
        exp_q.push_back(9);
        irq_in[9] = 1; irq_in[12] = 1;
        wait_req("svc_req");
        do_ack();
        #2;
        chk("pre_rst_insvc", 32'(bus.in_service), 1);
        RST = 1; irq_in = '0;
        #1;
        chk("arst_insvc", 32'(bus.in_service), 0);
        chk("arst_req", 32'(bus.irq_req), 0);
        chk("arst_id", 32'(bus.irq_id), 0);
        chk("arst_pending", 32'(pending), 0);
        cyc(1);
        RST = 0;
        cyc(3); @(negedge CK);
        chk("post_rst_idle", 32'(bus.irq_req), 0);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
